// File: rtl/cic_comp_fir_if.sv
// Sample stream into and filtered stream out of the CIC compensation FIR.
// Master drives samples and flush; slave returns results and status.
interface cic_comp_fir_if #(
    parameter int DATA_WIDTH = 4
);
    logic                         flush;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output flush, in_data, in_valid,
        input  out_data, out_valid, busy, overrun
    );

    modport slave (
        input  flush, in_data, in_valid,
        output out_data, out_valid, busy, overrun
    );
endinterface

// File: rtl/cic_comp_fir.sv
// Symmetric 8-tap Q6 droop compensation FIR with decimate-by-2.
// One multiplier is time-shared over the taps by an IDLE/MAC/OUT FSM.
module cic_comp_fir #(
    parameter int DATA_WIDTH = 4,
    parameter int COEF_WIDTH = 8,
    parameter int TAPS       = 8,
    parameter int DECIM      = 2,
    parameter int COEF_FRAC  = 6,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
    input logic           clk,
    input logic           rst_n,
    cic_comp_fir_if.slave bus
);

    localparam int KW     = $clog2(TAPS);
    localparam int PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] HALF_LSB =
        ACC_WIDTH'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    typedef logic signed [DATA_WIDTH-1:0] samp_t;

    function automatic logic signed [COEF_WIDTH-1:0] coef(
        input logic [KW-1:0] k
    );
        unique case (k)
            KW'(0):  coef = COEF_WIDTH'(-1);
            KW'(1):  coef = COEF_WIDTH'(3);
            KW'(2):  coef = COEF_WIDTH'(-8);
            KW'(3):  coef = COEF_WIDTH'(38);
            KW'(4):  coef = COEF_WIDTH'(38);
            KW'(5):  coef = COEF_WIDTH'(-8);
            KW'(6):  coef = COEF_WIDTH'(3);
            KW'(7):  coef = COEF_WIDTH'(-1);
            default: coef = '0;
        endcase
    endfunction

    state_t state_q, state_d;
    samp_t  dline_q [TAPS];
    samp_t  dline_d [TAPS];
    samp_t  snap_q  [TAPS];
    samp_t  snap_d  [TAPS];

    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic        [KW-1:0]         k_q, k_d;
    logic        [PW-1:0]         phase_q, phase_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         overrun_q, overrun_d;

    logic                         trig;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  rnd;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [DATA_WIDTH-1:0] sat;

    always_comb begin
        trig    = bus.in_valid && (phase_q == PW'(DECIM - 1));
        prod    = PROD_W'(snap_q[k_q]) * PROD_W'(coef(k_q));
        acc_sum = acc_q + ACC_WIDTH'(prod);
        rnd     = acc_sum + HALF_LSB;
        shifted = rnd >>> COEF_FRAC;
        if (shifted > SAT_HI) begin
            sat = SAT_HI[DATA_WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            sat = SAT_LO[DATA_WIDTH-1:0];
        end else begin
            sat = shifted[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        dline_d     = dline_q;
        snap_d      = snap_q;
        acc_d       = acc_q;
        k_d         = k_q;
        phase_d     = phase_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        // Sample intake is never stalled by the FSM.
        if (bus.in_valid) begin
            dline_d[0] = bus.in_data;
            for (int i = 1; i < TAPS; i++) begin
                dline_d[i] = dline_q[i-1];
            end
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    snap_d[0] = bus.in_data;
                    for (int i = 1; i < TAPS; i++) begin
                        snap_d[i] = dline_q[i-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(TAPS - 1)) begin
                    out_data_d  = sat;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (trig && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Flush wins over everything except the held result and sticky flag.
        if (bus.flush) begin
            for (int i = 0; i < TAPS; i++) begin
                dline_d[i] = '0;
                snap_d[i]  = '0;
            end
            acc_d       = '0;
            k_d         = '0;
            phase_d     = '0;
            state_d     = IDLE;
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
            overrun_d   = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                dline_q[i] <= '0;
                snap_q[i]  <= '0;
            end
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            phase_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dline_q     <= dline_d;
            snap_q      <= snap_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            phase_q     <= phase_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: directed scenarios plus random traffic,
// checked every cycle against a sample-history convolution model.
module tb_cic_comp_fir;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cic_comp_fir_if #(.DATA_WIDTH(4)) bus ();

    cic_comp_fir dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int C [8] = '{-1, 3, -8, 38, 38, -8, 3, -1};

    int hist [8];
    int nsamp      = 0;
    int busy_until = -100;
    int exp_cycle  = -1;
    int exp_val    = 0;
    int m_out      = 0;
    bit m_ovr      = 1'b0;
    int got     [$];
    int got_cyc [$];
    int acc_log [$];

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic int model_acc();
        int acc = 0;
        for (int k = 0; k < 8; k++) acc += C[k] * hist[k];
        return acc;
    endfunction

    function automatic int model_out(int acc);
        int r = (acc + 32) >>> 6;
        if (r > 7) r = 7;
        if (r < -8) r = -8;
        return r;
    endfunction

    function automatic int gq(int i);
        return (got.size() > i) ? got[i] : -99;
    endfunction

    function automatic int aq(int i);
        return (acc_log.size() > i) ? acc_log[i] : -9999;
    endfunction

    function automatic int cq(int i);
        return (got_cyc.size() > i) ? got_cyc[i] : -1;
    endfunction

    // Checks outputs of the current cycle, then applies its inputs to the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) hist[k] = 0;
            nsamp      = 0;
            busy_until = -100;
            exp_cycle  = -1;
            m_out      = 0;
            m_ovr      = 1'b0;
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_out_data", int'(bus.out_data), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_overrun", int'(bus.overrun), 0);
        end else begin
            if (exp_cycle == cyc) begin
                m_out     = exp_val;
                exp_cycle = -1;
                check("out_valid", int'(bus.out_valid), 1);
            end else begin
                check("out_valid", int'(bus.out_valid), 0);
            end
            if (bus.out_valid === 1'b1) begin
                got.push_back(int'(bus.out_data));
                got_cyc.push_back(cyc);
            end
            check("out_data", int'(bus.out_data), m_out);
            check("busy", int'(bus.busy), (cyc <= busy_until) ? 1 : 0);
            check("overrun", int'(bus.overrun), int'(m_ovr));

            if (bus.flush) begin
                for (int k = 0; k < 8; k++) hist[k] = 0;
                nsamp = 0;
                if (exp_cycle > cyc) exp_cycle = -1;
                if (busy_until > cyc) busy_until = cyc;
            end else if (bus.in_valid) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(bus.in_data);
                if (nsamp % 2 == 1) begin
                    if (cyc > busy_until) begin
                        exp_cycle  = cyc + 9;
                        exp_val    = model_out(model_acc());
                        busy_until = cyc + 9;
                        acc_log.push_back(model_acc());
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                nsamp++;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int gap);
        bus.in_data  = 4'(x);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        rst_n        = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    int base;
    int abase;
    int s0;
    int IMP [4] = '{0, 4, -1, 0};
    int SAT [8] = '{-8, 7, -8, 7, 7, -8, 7, -8};

    initial begin
        bus.flush    = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // DC level 4, one sample every 8 cycles
        base = got.size();
        for (int i = 0; i < 16; i++) send(4, 8);
        repeat (12) tick();
        check("dc_count", got.size() - base, 8);
        for (int i = 3; i < 8; i++) check("dc_value", gq(base + i), 4);
        check("dc_overrun", int'(bus.overrun), 0);

        // Impulse response
        do_flush();
        base = got.size();
        send(7, 8);
        for (int i = 0; i < 9; i++) send(0, 8);
        repeat (12) tick();
        for (int i = 0; i < 4; i++) check("impulse", gq(base + i), IMP[i]);
        for (int i = 4; i < 5; i++) check("impulse_tail", gq(base + i), 0);

        // Saturating pattern
        do_flush();
        base  = got.size();
        abase = acc_log.size();
        for (int i = 0; i < 8; i++) send(SAT[i], 8);
        repeat (12) tick();
        check("sat_count", got.size() - base, 4);
        check("sat_acc", aq(abase + 3), 718);
        check("sat_out", gq(base + 3), 7);

        // Back-to-back samples overrun the FSM
        do_reset();
        base = got.size();
        s0   = cyc;
        for (int i = 0; i < 12; i++) send(3, 1);
        repeat (15) tick();
        check("ovr_count", got.size() - base, 2);
        check("ovr_first_lat", cq(base) - s0, 10);
        check("ovr_flag", int'(bus.overrun), 1);
        for (int i = 0; i < 4; i++) send(1, 8);
        do_flush();
        repeat (3) tick();
        check("ovr_sticky", int'(bus.overrun), 1);
        do_reset();
        check("ovr_cleared", int'(bus.overrun), 0);

        // Flush three cycles after a trigger
        base = got.size();
        send(4, 1);
        send(4, 1);
        repeat (2) tick();
        do_flush();
        check("flush_busy", int'(bus.busy), 0);
        repeat (12) tick();
        check("flush_no_out", got.size() - base, 0);
        base = got.size();
        for (int i = 0; i < 16; i++) send(4, 8);
        repeat (12) tick();
        check("flush_refill0", gq(base), 0);
        check("flush_refill7", gq(base + 7), 4);

        // Reset during MAC
        base = got.size();
        send(4, 1);
        send(4, 1);
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_mid_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        repeat (12) tick();
        check("rst_no_out", got.size() - base, 0);
        base = got.size();
        for (int i = 0; i < 16; i++) send(4, 8);
        repeat (12) tick();
        check("rst_dc", gq(base + 7), 4);

        // Random traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            bus.flush    = ($urandom_range(0, 59) == 0);
            bus.in_valid = ($urandom_range(0, 3) == 0);
            bus.in_data  = 4'($urandom_range(0, 15));
            tick();
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (15) tick();
        check("drain", exp_cycle, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
